// File: rtl/stack_pkg.sv
// Shared encodings and default geometry for the hardware stack sequencer.
package stack_pkg;

    localparam int         DEF_ADDR_W      = 9;
    localparam logic [8:0] DEF_STACK_TOP   = 9'h1FF;
    localparam int         DEF_STACK_DEPTH = 256;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_PUSH = 3'd1,
        OP_POP  = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4,
        OP_LDSP = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUSH_WR,
        ST_POP_RD,
        ST_POP_CAP
    } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack-pointer owner and PUSH/POP/CALL/RET/LDSP sequencer in front of DataMemory.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] STACK_TOP   = ADDR_W'(DEF_STACK_TOP),
    parameter int                STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_data,
    input  logic [15:0] ret_pc,
    output logic [15:0] mem_data_in,
    output logic [15:0] mem_sp,
    output logic        mem_push,
    output logic        mem_pop,
    input  logic [15:0] mem_data_out,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic        pc_load,
    output logic [15:0] pc_target,
    output logic [15:0] sp_out,
    output logic        stack_full,
    output logic        stack_empty,
    output logic        fault,
    input  logic        fault_clr
);

    localparam logic [ADDR_W-1:0] SP_LO     = ADDR_W'(int'(STACK_TOP) - STACK_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_MAX = ADDR_W'(STACK_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       target_q, target_d;
    logic              ctl_q, ctl_d;
    logic              uflow_q, uflow_d;
    logic              fault_q, fault_d;
    logic              fault_set;
    logic [ADDR_W-1:0] depth;
    logic [ADDR_W-1:0] sp_inc;
    logic              ldsp_ok;

    assign depth       = STACK_TOP - sp_q;
    assign sp_inc      = sp_q + ADDR_W'(1);
    assign stack_full  = (depth == DEPTH_MAX);
    assign stack_empty = (sp_q == STACK_TOP);
    assign sp_out      = {{(16-ADDR_W){1'b0}}, sp_q};
    assign fault       = fault_q;
    assign ldsp_ok     = (req_data[15:ADDR_W] == '0) &&
                         (req_data[ADDR_W-1:0] >= SP_LO) &&
                         (req_data[ADDR_W-1:0] <= STACK_TOP);

    // ctl_q marks the in-flight transfer as CALL (push side) or RET (pop side).
    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        wdata_d   = wdata_q;
        target_d  = target_q;
        ctl_d     = ctl_q;
        uflow_d   = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    case (req_op)
                        OP_PUSH, OP_CALL: begin
                            if (stack_full) begin
                                fault_set = 1'b1;
                            end else begin
                                state_d  = ST_PUSH_WR;
                                wdata_d  = (req_op == OP_CALL) ? ret_pc : req_data;
                                target_d = req_data;
                                ctl_d    = (req_op == OP_CALL);
                            end
                        end
                        OP_POP, OP_RET: begin
                            if (stack_empty) begin
                                fault_set = 1'b1;
                                uflow_d   = 1'b1;
                            end else begin
                                state_d = ST_POP_RD;
                                ctl_d   = (req_op == OP_RET);
                            end
                        end
                        OP_LDSP: begin
                            if (ldsp_ok) sp_d = req_data[ADDR_W-1:0];
                            else         fault_set = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_PUSH_WR: begin
                sp_d    = sp_q - ADDR_W'(1);
                state_d = ST_IDLE;
            end
            ST_POP_RD: begin
                sp_d    = sp_inc;
                state_d = ST_POP_CAP;
            end
            ST_POP_CAP: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        fault_d = fault_set | (fault_q & ~fault_clr);
    end

    // Memory read data arrives during POP_CAP and is forwarded straight to writeback/PC.
    always_comb begin
        req_ready   = (state_q == ST_IDLE);
        mem_push    = (state_q == ST_PUSH_WR);
        mem_pop     = (state_q == ST_POP_RD);
        mem_sp      = {{(16-ADDR_W){1'b0}}, (state_q == ST_POP_RD) ? sp_inc : sp_q};
        mem_data_in = '0;
        resp_valid  = uflow_q;
        resp_err    = uflow_q;
        resp_data   = '0;
        pc_load     = 1'b0;
        pc_target   = '0;
        if (state_q == ST_PUSH_WR) begin
            mem_data_in = wdata_q;
            if (ctl_q) begin
                pc_load   = 1'b1;
                pc_target = target_q;
            end
        end
        if (state_q == ST_POP_CAP) begin
            resp_valid = 1'b1;
            resp_data  = mem_data_out;
            if (ctl_q) begin
                pc_load   = 1'b1;
                pc_target = mem_data_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sp_q    <= STACK_TOP;
            ctl_q   <= 1'b0;
            uflow_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            ctl_q   <= ctl_d;
            uflow_q <= uflow_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        wdata_q  <= wdata_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed and randomized bench for stack_ctrl against a reference stack model.
module tb_stack_ctrl;
    import stack_pkg::*;

    localparam int TOP = 32'h1FF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [15:0] req_data = 16'h0;
    logic [15:0] ret_pc = 16'h0;
    logic [15:0] mem_data_in;
    logic [15:0] mem_sp;
    logic        mem_push;
    logic        mem_pop;
    logic [15:0] mem_data_out;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        resp_err;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [15:0] sp_out;
    logic        stack_full;
    logic        stack_empty;
    logic        fault;
    logic        fault_clr = 1'b0;

    stack_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data), .ret_pc(ret_pc),
        .mem_data_in(mem_data_in), .mem_sp(mem_sp), .mem_push(mem_push),
        .mem_pop(mem_pop), .mem_data_out(mem_data_out), .resp_valid(resp_valid),
        .resp_data(resp_data), .resp_err(resp_err), .pc_load(pc_load),
        .pc_target(pc_target), .sp_out(sp_out), .stack_full(stack_full),
        .stack_empty(stack_empty), .fault(fault), .fault_clr(fault_clr)
    );

    always #5 clk = ~clk;

    // DataMemory stand-in: synchronous write on push, registered read on pop.
    logic [15:0] dmem [512];
    logic [15:0] dmem_out = 16'h0;
    logic        mem_clear = 1'b1;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 512; i++) dmem[i] <= 16'h0;
        end else begin
            if (mem_push) dmem[mem_sp[8:0]] <= mem_data_in;
            if (mem_pop)  dmem_out <= dmem[mem_sp[8:0]];
        end
    end
    assign mem_data_out = dmem_out;

    int          checks = 0;
    int          errors = 0;
    int          m_sp;
    bit          m_fault;
    logic [15:0] m_mem [512];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_sp"}, sp_out, m_sp);
        chk({tag, "_fault"}, fault, m_fault);
        chk({tag, "_empty"}, stack_empty, m_sp == TOP);
        chk({tag, "_full"}, stack_full, (TOP - m_sp) == 256);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        fault_clr = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_sp = TOP;
        m_fault = 1'b0;
        chk("rst_ready", req_ready, 1);
        chk("rst_push", mem_push, 0);
        chk("rst_pop", mem_pop, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_pc_load", pc_load, 0);
        chk("rst_pc_target", pc_target, 0);
        chk("rst_mem_data_in", mem_data_in, 0);
        chk("rst_mem_sp", mem_sp, TOP);
        check_flags("rst");
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        m_fault = 1'b0;
        chk("fault_clr", fault, 0);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [15:0] data, input logic [15:0] rpc);
        int          n;
        bit          full;
        bit          empty;
        logic [15:0] wv;
        logic [15:0] exp;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("ready_wait", req_ready, 1);
        full  = (TOP - m_sp) == 256;
        empty = (m_sp == TOP);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        ret_pc    = rpc;
        step();
        req_valid = 1'b0;
        req_op    = 3'd0;
        case (op)
            OP_PUSH, OP_CALL: begin
                if (full) begin
                    m_fault = 1'b1;
                    chk("ovf_push", mem_push, 0);
                    chk("ovf_pc_load", pc_load, 0);
                    chk("ovf_ready", req_ready, 1);
                end else begin
                    wv = (op == OP_CALL) ? rpc : data;
                    chk("push_strobe", mem_push, 1);
                    chk("push_sp", mem_sp, m_sp);
                    chk("push_data", mem_data_in, wv);
                    chk("push_pc_load", pc_load, op == OP_CALL);
                    if (op == OP_CALL) chk("call_target", pc_target, data);
                    chk("push_busy", req_ready, 0);
                    m_mem[m_sp] = wv;
                    m_sp--;
                    step();
                    chk("push_done_strobe", mem_push, 0);
                    chk("push_done_ready", req_ready, 1);
                end
            end
            OP_POP, OP_RET: begin
                if (empty) begin
                    m_fault = 1'b1;
                    chk("udf_valid", resp_valid, 1);
                    chk("udf_err", resp_err, 1);
                    chk("udf_data", resp_data, 0);
                    chk("udf_pop", mem_pop, 0);
                    chk("udf_pc_load", pc_load, 0);
                    check_flags("udf");
                    step();
                    chk("udf_pulse_end", resp_valid, 0);
                end else begin
                    chk("pop_strobe", mem_pop, 1);
                    chk("pop_sp", mem_sp, m_sp + 1);
                    chk("pop_early_valid", resp_valid, 0);
                    chk("pop_busy", req_ready, 0);
                    m_sp++;
                    exp = m_mem[m_sp];
                    step();
                    chk("pop_valid", resp_valid, 1);
                    chk("pop_err", resp_err, 0);
                    chk("pop_data", resp_data, exp);
                    chk("pop_pc_load", pc_load, op == OP_RET);
                    if (op == OP_RET) chk("ret_target", pc_target, exp);
                    step();
                    chk("pop_pulse_end", resp_valid, 0);
                end
            end
            OP_LDSP: begin
                if (data >= 16'h00FF && data <= 16'h01FF) m_sp = int'(data);
                else m_fault = 1'b1;
            end
            default: begin
                chk("nop_push", mem_push, 0);
                chk("nop_resp", resp_valid, 0);
            end
        endcase
        check_flags("op");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [15:0] d;
        int          r;
        for (int i = 0; i < 512; i++) m_mem[i] = 16'h0;
        step();
        mem_clear = 1'b0;
        do_reset();

        run_op(OP_PUSH, 16'hAAAA, 16'h0);
        run_op(OP_PUSH, 16'hF0F0, 16'h0);
        run_op(OP_POP, 16'h0, 16'h0);
        run_op(OP_POP, 16'h0, 16'h0);
        chk("plan1_sp", sp_out, 16'h01FF);
        chk("plan1_empty", stack_empty, 1);

        run_op(OP_CALL, 16'h0040, 16'h0013);
        run_op(OP_RET, 16'h0, 16'h0);

        for (int i = 0; i < 256; i++) run_op(OP_PUSH, 16'(i * 7 + 3), 16'h0);
        chk("fill_full", stack_full, 1);
        chk("fill_sp", sp_out, 16'h00FF);
        run_op(OP_PUSH, 16'hDEAD, 16'h0);
        chk("ovf_fault", fault, 1);
        clear_fault();

        do_reset();
        run_op(OP_POP, 16'h0, 16'h0);
        chk("udf_fault", fault, 1);

        run_op(OP_LDSP, 16'h0180, 16'h0);
        chk("ldsp_ok_sp", sp_out, 16'h0180);
        run_op(OP_LDSP, 16'h0050, 16'h0);
        chk("ldsp_bad_sp", sp_out, 16'h0180);
        chk("ldsp_bad_fault", fault, 1);

        do_reset();
        run_op(OP_PUSH, 16'h1234, 16'h0);
        req_valid = 1'b1;
        req_op    = OP_POP;
        step();
        chk("abort_pop_rd", mem_pop, 1);
        chk("abort_busy", req_ready, 0);
        rst_n = 1'b0;
        step();
        req_valid = 1'b0;
        req_op    = 3'd0;
        rst_n     = 1'b1;
        m_sp      = TOP;
        m_fault   = 1'b0;
        chk("abort_ready", req_ready, 1);
        chk("abort_resp", resp_valid, 0);
        chk("abort_pop", mem_pop, 0);
        check_flags("abort");
        step();
        chk("abort_resp_late", resp_valid, 0);
        chk("abort_pc_load", pc_load, 0);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 35) op = OP_PUSH;
            else if (r < 62) op = OP_POP;
            else if (r < 70) op = OP_CALL;
            else if (r < 80) op = OP_RET;
            else if (r < 88) op = OP_LDSP;
            else if (r < 93) op = OP_NOP;
            else             op = 3'($urandom_range(6, 7));
            d = 16'($urandom);
            if (op == OP_LDSP && $urandom_range(0, 1) == 1) d = 16'($urandom_range(255, 511));
            run_op(op, d, 16'($urandom));
            if ($urandom_range(0, 9) == 0) clear_fault();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
